// File: rtl/maindec_pkg.sv
// Shared opcode/funct constants and control-field encodings for the main decoder.
package maindec_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b000001;
    localparam logic [5:0] OP_SW    = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b000011;
    localparam logic [5:0] OP_SUBI  = 6'b000100;
    localparam logic [5:0] OP_BEQ   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000111;
    localparam logic [5:0] OP_JAL   = 6'b001000;

    localparam logic [5:0] FUNCT_JR = 6'b001000;

    typedef enum logic [1:0] {
        JUMP_SEQ = 2'b00,
        JUMP_TGT = 2'b01,
        JUMP_REG = 2'b10
    } jump_e;

    typedef enum logic [1:0] {
        REGDST_RT  = 2'b00,
        REGDST_RD  = 2'b01,
        REGDST_R31 = 2'b10
    } regdst_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } memtoreg_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } aluop_e;

    typedef struct packed {
        memtoreg_e memtoreg;
        logic      memwrite;
        logic      branch;
        logic      alusrc;
        regdst_e   regdst;
        logic      regwrite;
        jump_e     jump;
        aluop_e    aluop;
    } ctrl_t;

endpackage

// File: rtl/maindec.sv
// Main control decoder: combinational opcode/funct decode into one registered control bank.
module maindec
    import maindec_pkg::*;
#(
    parameter int N = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [1:0] memtoreg,
    output logic       memwrite,
    output logic       branch,
    output logic       alusrc,
    output logic [1:0] regdst,
    output logic       regwrite,
    output logic [1:0] jump,
    output logic [1:0] aluop
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    // N only exists so datapath instantiations can pass their width through.
    if (N < 1) begin : g_width_unused
    end

    // Unknown or unassigned opcodes (including X/Z bits) fall to the all-zero NOP.
    always_comb begin
        ctrl_d = '0;
        case (op)
            OP_RTYPE: begin
                if (funct == FUNCT_JR) begin
                    ctrl_d.jump = JUMP_REG;
                end else begin
                    ctrl_d.regwrite = 1'b1;
                    ctrl_d.regdst   = REGDST_RD;
                    ctrl_d.aluop    = ALU_FUNCT;
                end
            end
            OP_LW: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.memtoreg = WB_MEM;
            end
            OP_SW: begin
                ctrl_d.memwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
            end
            OP_ADDI: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
            end
            OP_SUBI: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.aluop    = ALU_SUB;
            end
            OP_BEQ: begin
                ctrl_d.branch = 1'b1;
                ctrl_d.aluop  = ALU_SUB;
            end
            OP_J: begin
                ctrl_d.jump = JUMP_TGT;
            end
            OP_JAL: begin
                ctrl_d.jump     = JUMP_TGT;
                ctrl_d.regwrite = 1'b1;
                ctrl_d.regdst   = REGDST_R31;
                ctrl_d.memtoreg = WB_PC4;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign memtoreg = ctrl_q.memtoreg;
    assign memwrite = ctrl_q.memwrite;
    assign branch   = ctrl_q.branch;
    assign alusrc   = ctrl_q.alusrc;
    assign regdst   = ctrl_q.regdst;
    assign regwrite = ctrl_q.regwrite;
    assign jump     = ctrl_q.jump;
    assign aluop    = ctrl_q.aluop;

endmodule

// File: tb/tb_maindec.sv
// Directed self-checking bench for maindec; control bits packed as
// {memtoreg[1:0], memwrite, branch, alusrc, regdst[1:0], regwrite, jump[1:0], aluop[1:0]}.
module tb_maindec;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic [1:0] memtoreg;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic [1:0] regdst;
    logic       regwrite;
    logic [1:0] jump;
    logic [1:0] aluop;

    logic [12:0] obs;
    int checks = 0;
    int errors = 0;

    localparam logic [12:0] E_NOP   = 13'b00_0_0_0_00_0_00_00;
    localparam logic [12:0] E_RTYPE = 13'b00_0_0_0_01_1_00_10;
    localparam logic [12:0] E_JR    = 13'b00_0_0_0_00_0_10_00;
    localparam logic [12:0] E_LW    = 13'b01_0_0_1_00_1_00_00;
    localparam logic [12:0] E_SW    = 13'b00_1_0_1_00_0_00_00;
    localparam logic [12:0] E_ADDI  = 13'b00_0_0_1_00_1_00_00;
    localparam logic [12:0] E_SUBI  = 13'b00_0_0_1_00_1_00_01;
    localparam logic [12:0] E_BEQ   = 13'b00_0_1_0_00_0_00_01;
    localparam logic [12:0] E_J     = 13'b00_0_0_0_00_0_01_00;
    localparam logic [12:0] E_JAL   = 13'b10_0_0_0_10_1_01_00;

    maindec #(.N(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (op),
        .funct    (funct),
        .memtoreg (memtoreg),
        .memwrite (memwrite),
        .branch   (branch),
        .alusrc   (alusrc),
        .regdst   (regdst),
        .regwrite (regwrite),
        .jump     (jump),
        .aluop    (aluop)
    );

    assign obs = {memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump, aluop};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        op    = 6'b000011;
        funct = 6'b000000;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs !== E_NOP) begin
                errors++;
                $display("[TB] FAIL reset_edge%0d: got %b expected %b", i, obs, E_NOP);
            end
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (obs !== E_ADDI) begin
            errors++;
            $display("[TB] FAIL reset_release_addi: got %b expected %b", obs, E_ADDI);
        end
    endtask

    task automatic test_rtype_jr();
        op    = 6'b000000;
        funct = 6'b000111;
        step();
        checks++;
        if (obs !== E_RTYPE) begin
            errors++;
            $display("[TB] FAIL rtype: got %b expected %b", obs, E_RTYPE);
        end
        funct = 6'b001000;
        step();
        checks++;
        if (obs !== E_JR) begin
            errors++;
            $display("[TB] FAIL jr: got %b expected %b", obs, E_JR);
        end
        funct = 6'b100000;
        step();
        checks++;
        if (obs !== E_RTYPE) begin
            errors++;
            $display("[TB] FAIL rtype_add: got %b expected %b", obs, E_RTYPE);
        end
    endtask

    task automatic test_back_to_back();
        funct = 6'b001000;
        op    = 6'b000001;
        step();
        checks++;
        if (obs !== E_LW) begin
            errors++;
            $display("[TB] FAIL b2b_lw: got %b expected %b", obs, E_LW);
        end
        op = 6'b000010;
        step();
        checks++;
        if (obs !== E_SW) begin
            errors++;
            $display("[TB] FAIL b2b_sw: got %b expected %b", obs, E_SW);
        end
    endtask

    task automatic test_branch_subi();
        op = 6'b000101;
        step();
        checks++;
        if (obs !== E_BEQ) begin
            errors++;
            $display("[TB] FAIL beq: got %b expected %b", obs, E_BEQ);
        end
        op = 6'b000100;
        step();
        checks++;
        if (obs !== E_SUBI) begin
            errors++;
            $display("[TB] FAIL subi: got %b expected %b", obs, E_SUBI);
        end
    endtask

    task automatic test_jumps();
        op = 6'b000111;
        step();
        checks++;
        if (obs !== E_J) begin
            errors++;
            $display("[TB] FAIL j: got %b expected %b", obs, E_J);
        end
        op = 6'b001000;
        step();
        checks++;
        if (obs !== E_JAL) begin
            errors++;
            $display("[TB] FAIL jal: got %b expected %b", obs, E_JAL);
        end
    endtask

    task automatic test_nop_and_x();
        op    = 6'b101010;
        funct = 6'bxxxxxx;
        step();
        checks++;
        if (obs !== E_NOP) begin
            errors++;
            $display("[TB] FAIL nop_101010_xfunct: got %b expected %b", obs, E_NOP);
        end
        op = 6'b000110;
        step();
        checks++;
        if (obs !== E_NOP) begin
            errors++;
            $display("[TB] FAIL nop_000110: got %b expected %b", obs, E_NOP);
        end
        op = 6'b1x1x1x;
        step();
        checks++;
        if (obs !== E_NOP) begin
            errors++;
            $display("[TB] FAIL nop_xop: got %b expected %b", obs, E_NOP);
        end
        op    = 6'bxxxxxx;
        funct = 6'b000000;
        step();
        checks++;
        if ($isunknown(obs)) begin
            errors++;
            $display("[TB] FAIL xop_no_x: got %b expected no X/Z bits", obs);
        end
    endtask

    task automatic test_funct_ignored();
        op    = 6'b000011;
        funct = 6'b001000;
        step();
        checks++;
        if (obs !== E_ADDI) begin
            errors++;
            $display("[TB] FAIL addi_funct_jr: got %b expected %b", obs, E_ADDI);
        end
    endtask

    task automatic test_mid_reset();
        op    = 6'b000001;
        funct = 6'b000000;
        rst_n = 1'b0;
        step();
        checks++;
        if (obs !== E_NOP) begin
            errors++;
            $display("[TB] FAIL mid_reset: got %b expected %b", obs, E_NOP);
        end
        rst_n = 1'b1;
        op    = 6'b000010;
        step();
        checks++;
        if (obs !== E_SW) begin
            errors++;
            $display("[TB] FAIL mid_reset_release: got %b expected %b", obs, E_SW);
        end
    endtask

    task automatic test_invariants();
        logic [5:0] ops [10] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd42};
        for (int i = 0; i < 10; i++) begin
            op    = ops[i];
            funct = 6'b000001;
            step();
            checks++;
            if ((memwrite && regwrite) || (branch && (jump != 2'b00))) begin
                errors++;
                $display("[TB] FAIL invariant_op%0d: got %b expected no write/branch conflict", ops[i], obs);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        op    = 6'b0;
        funct = 6'b0;
        test_reset();
        test_rtype_jr();
        test_back_to_back();
        test_branch_subi();
        test_jumps();
        test_nop_and_x();
        test_funct_ignored();
        test_mid_reset();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
